// File: rtl/cc_pkg.sv
// rtl/cc_pkg.sv - shared types and constants for the cache-controller dispatch stage
// Purpose: FSM state type and the fixed AXI AR burst attributes used by cc_reorder_dispatch_ctrl.
// Ports: none (package).
package cc_pkg;

  typedef enum logic {S_IDLE, S_AR} cc_disp_state_t;

  // Every miss fetches one full 512-bit line as 8 x 64-bit beats, critical word first.
  localparam logic [3:0] CC_ARLEN        = 4'd7;
  localparam logic [2:0] CC_ARSIZE       = 3'b011;
  localparam logic [1:0] CC_ARBURST_WRAP = 2'b10;

  localparam int CC_LINE_W = 512;
  localparam int CC_OFS_W  = 6;

endpackage

// File: rtl/cc_credit_counter.sv
// rtl/cc_credit_counter.sv - in-flight miss burst credit counter
// Purpose: counts miss bursts issued but not yet fully returned.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   inc         a miss burst was accepted this cycle
//   dec         an R last-beat handshake was seen this cycle
//   max         credit limit
//   count       current in-flight count
//   avail       count < max, a new miss may be accepted
//   err         sticky: a last beat arrived with nothing outstanding
module cc_credit_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       dec,
  input  logic [3:0] max,
  output logic [3:0] count,
  output logic       avail,
  output logic       err
);

  logic underflow;
  logic dec_eff;

  // A return with nothing outstanding is flagged and otherwise ignored.
  assign underflow = dec && (count == 4'd0);
  assign dec_eff   = dec && !underflow;
  assign avail     = (count < max);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 4'd0;
      err   <= 1'b0;
    end else begin
      if (underflow) begin
        err <= 1'b1;
      end
      if (inc && !dec_eff) begin
        count <= count + 4'd1;
      end else if (dec_eff && !inc) begin
        count <= count - 4'd1;
      end
    end
  end

endmodule

// File: rtl/cc_reorder_dispatch_ctrl.sv
// rtl/cc_reorder_dispatch_ctrl.sv - dispatch of tag-lookup results to the reorder unit and MEM AR
// Purpose: every accepted lookup pushes a hit/miss flag; hits also push {offset,line} into the hit-data
//   FIFO; misses issue an 8-beat WRAP AR burst, capped by a credit counter fed from R last-beat handshakes.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   lookup_valid_i/ready_o             lookup handshake; hit_i, addr_i, line_i are the lookup payload
//   hit_flag_fifo_afull_i/wren_o/wdata_o  hit-flag FIFO write port (1 = hit)
//   hit_data_fifo_afull_i/wren_o/wdata_o  hit-data FIFO write port {addr offset, line}
//   mem_araddr/arlen/arsize/arburst/arvalid_o, mem_arready_i   MEM AR channel
//   mem_rvalid_i/rready_i/rlast_i      snooped MEM R handshake for credit return
//   outstanding_o                      in-flight miss count
//   credit_err_o                       sticky credit underflow flag
module cc_reorder_dispatch_ctrl
  import cc_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int LINE_WIDTH      = CC_LINE_W,
  parameter int OFFSET_WIDTH    = CC_OFS_W
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              lookup_valid_i,
  output logic                              lookup_ready_o,
  input  logic                              lookup_hit_i,
  input  logic [ADDR_WIDTH-1:0]             lookup_addr_i,
  input  logic [LINE_WIDTH-1:0]             lookup_line_i,
  input  logic                              hit_flag_fifo_afull_i,
  output logic                              hit_flag_fifo_wren_o,
  output logic                              hit_flag_fifo_wdata_o,
  input  logic                              hit_data_fifo_afull_i,
  output logic                              hit_data_fifo_wren_o,
  output logic [OFFSET_WIDTH+LINE_WIDTH-1:0] hit_data_fifo_wdata_o,
  output logic [ADDR_WIDTH-1:0]             mem_araddr_o,
  output logic [3:0]                        mem_arlen_o,
  output logic [2:0]                        mem_arsize_o,
  output logic [1:0]                        mem_arburst_o,
  output logic                              mem_arvalid_o,
  input  logic                              mem_arready_i,
  input  logic                              mem_rvalid_i,
  input  logic                              mem_rready_i,
  input  logic                              mem_rlast_i,
  output logic [3:0]                        outstanding_o,
  output logic                              credit_err_o
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

  cc_disp_state_t state, state_next;

  logic credit_avail;
  logic accept;
  logic hit_accept;
  logic miss_accept;
  logic credit_return;

  assign mem_arlen_o   = CC_ARLEN;
  assign mem_arsize_o  = CC_ARSIZE;
  assign mem_arburst_o = CC_ARBURST_WRAP;

  // The AR request lives exactly as long as the FSM is in S_AR, so reset drops it immediately.
  assign mem_arvalid_o = (state == S_AR);

  assign accept        = lookup_valid_i && lookup_ready_o;
  assign hit_accept    = accept && lookup_hit_i;
  assign miss_accept   = accept && !lookup_hit_i;
  assign credit_return = mem_rvalid_i && mem_rready_i && mem_rlast_i;

  cc_credit_counter u_credit (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (miss_accept),
    .dec   (credit_return),
    .max   (MAX_CNT),
    .count (outstanding_o),
    .avail (credit_avail),
    .err   (credit_err_o)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next     = state;
    lookup_ready_o = 1'b0;
    case (state)
      S_IDLE: begin
        // A hit needs room in both FIFOs; a miss needs a flag slot and a credit.
        lookup_ready_o = !hit_flag_fifo_afull_i &&
                         (lookup_hit_i ? !hit_data_fifo_afull_i : credit_avail);
        if (miss_accept) begin
          state_next = S_AR;
        end
      end
      S_AR: begin
        if (mem_arready_i) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // FIFO writes and AR address are registered: one cycle after the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_flag_fifo_wren_o  <= 1'b0;
      hit_flag_fifo_wdata_o <= 1'b0;
      hit_data_fifo_wren_o  <= 1'b0;
      hit_data_fifo_wdata_o <= '0;
      mem_araddr_o          <= '0;
    end else begin
      hit_flag_fifo_wren_o  <= accept;
      hit_flag_fifo_wdata_o <= hit_accept;
      hit_data_fifo_wren_o  <= hit_accept;
      if (hit_accept) begin
        hit_data_fifo_wdata_o <= {lookup_addr_i[OFFSET_WIDTH-1:0], lookup_line_i};
      end
      if (miss_accept) begin
        mem_araddr_o <= {lookup_addr_i[ADDR_WIDTH-1:3], 3'b000};
      end
    end
  end

endmodule
